// File: rtl/output_signature_monitor_if.sv
// -----------------------------------------------------------------------------
// output_signature_monitor_if
// Bundles the control, sample and result signals of output_signature_monitor.
//   master : the environment side (drives start/clear/sample_valid/y_in/ack,
//            observes busy/sig/sig_valid/event_count/alarm)
//   slave  : the monitor side (the reverse directions)
// Signals:
//   start        single-cycle request to open a window
//   clear        synchronous abort to IDLE
//   sample_valid y_in is valid this cycle
//   y_in[19:0]   observed FSM outputs, bit i-1 carries y_i
//   ack          consumer acknowledges the completed signature
//   busy         window is collecting
//   sig[19:0]    MISR signature
//   sig_valid    signature complete, waiting for ack
//   event_count  event samples seen in the current or last window
//   alarm        event threshold reached in the current or last window
// -----------------------------------------------------------------------------
interface output_signature_monitor_if;
    logic        start;
    logic        clear;
    logic        sample_valid;
    logic [19:0] y_in;
    logic        ack;
    logic        busy;
    logic [19:0] sig;
    logic        sig_valid;
    logic [7:0]  event_count;
    logic        alarm;

    modport master (
        output start, clear, sample_valid, y_in, ack,
        input  busy, sig, sig_valid, event_count, alarm
    );

    modport slave (
        input  start, clear, sample_valid, y_in, ack,
        output busy, sig, sig_valid, event_count, alarm
    );
endinterface

// File: rtl/output_signature_monitor.sv
// -----------------------------------------------------------------------------
// output_signature_monitor
// Compresses WIN valid samples of an upstream FSM's output vector into a
// 20-bit MISR signature and optionally counts "event" samples selected by
// EVT_MASK, raising a sticky alarm once ALARM_TH events are seen in a window.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  output_signature_monitor_if.slave (see interface for signal list)
//
// Parameters:
//   WIN      valid samples per window (1..65535)
//   SEED     MISR value loaded at window start and on reset
//   EVT_MASK y_in bits that mark a sample as an event
//   ALARM_TH event count at which alarm asserts (1..255)
//
// Configuration macro:
//   MON_ALARM_EN  defined   -> event counter and alarm are built
//                 undefined -> event_count = 0, alarm = 0, no event flops
// -----------------------------------------------------------------------------
module output_signature_monitor #(
    parameter int unsigned WIN      = 64,
    parameter logic [19:0] SEED     = 20'h00000,
    parameter logic [19:0] EVT_MASK = 20'h00008,
    parameter int unsigned ALARM_TH = 5
) (
    input logic                         clk,
    input logic                         rst,
    output_signature_monitor_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [15:0] WIN_LAST = 16'(WIN - 1);

    state_t      state_q;
    state_t      state_d;
    logic [19:0] sig_q;
    logic [15:0] sample_cnt_q;
    logic        busy;
    logic        sig_valid;

    // clear overrides everything, so neither a window start nor a sample is
    // honoured in a cycle where clear is high.
    logic window_start;
    logic sample_fire;
    logic last_sample;

    assign window_start = (state_q == IDLE)    && bus.start        && !bus.clear;
    assign sample_fire  = (state_q == COLLECT) && bus.sample_valid && !bus.clear;
    assign last_sample  = sample_fire && (sample_cnt_q == WIN_LAST);

    // Feedback taps 19 and 16 enter at bit 0; every other bit shifts up.
    logic [19:0] misr_next;
    assign misr_next = {sig_q[18:0], sig_q[19] ^ sig_q[16]} ^ bus.y_in;

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential state uses non-blocking (<=) so all flops sample the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        sig_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                if (last_sample) state_d = DONE;
            end
            DONE: begin
                sig_valid = 1'b1;
                // A concurrent start is simply not looked at here.
                if (bus.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.clear) state_d = IDLE;
    end

    // ------------------------------------------------------------- datapath
    // sig holds through clear, IDLE and DONE; it only moves on a window
    // start (reload) or an accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SEED;
        end else if (window_start) begin
            sig_q <= SEED;
        end else if (sample_fire) begin
            sig_q <= misr_next;
        end
    end

    // Counts up to WIN at most, which fits 16 bits for every legal WIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= 16'd0;
        end else if (window_start) begin
            sample_cnt_q <= 16'd0;
        end else if (sample_fire) begin
            sample_cnt_q <= sample_cnt_q + 16'd1;
        end
    end

`ifdef MON_ALARM_EN
    localparam logic [7:0] ALARM_LEVEL = 8'(ALARM_TH);

    logic [7:0] event_cnt_q;
    logic       alarm_q;
    logic       evt_hit;

    assign evt_hit = sample_fire && ((bus.y_in & EVT_MASK) != 20'h00000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt_q <= 8'd0;
            alarm_q     <= 1'b0;
        end else if (bus.clear || window_start) begin
            event_cnt_q <= 8'd0;
            alarm_q     <= 1'b0;
        end else if (evt_hit && (event_cnt_q != 8'hFF)) begin
            event_cnt_q <= event_cnt_q + 8'd1;
            // Sticky: set on the crossing edge, only cleared by start/clear/rst.
            if (event_cnt_q + 8'd1 == ALARM_LEVEL) alarm_q <= 1'b1;
        end
    end

    assign bus.event_count = event_cnt_q;
    assign bus.alarm       = alarm_q;
`else
    // Event logic is compiled out; keep the parameters referenced.
    logic unused_evt_cfg;
    assign unused_evt_cfg  = ^{EVT_MASK, 8'(ALARM_TH)};
    assign bus.event_count = 8'h00;
    assign bus.alarm       = 1'b0;
`endif

    assign bus.busy      = busy;
    assign bus.sig_valid = sig_valid;
    assign bus.sig       = sig_q;

endmodule

// File: tb/tb_output_signature_monitor.sv
// -----------------------------------------------------------------------------
// tb_output_signature_monitor
// Three monitor instances (WIN = 1, 2, 8, all SEED = 0) driven by directed
// vectors. Expected signatures are pushed into per-instance queues when a
// window is started; monitor processes pop and compare whenever an instance
// raises sig_valid. Cycle-level behaviour (latency, reset, clear, handshakes)
// is checked inline. Event/alarm expectations follow MON_ALARM_EN.
// -----------------------------------------------------------------------------
module tb_output_signature_monitor;

`ifdef MON_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    typedef struct {
        logic [19:0] sig;
        logic [7:0]  ec;
        logic        alarm;
    } exp_t;

    logic clk;
    logic rst;

    output_signature_monitor_if bus1 ();
    output_signature_monitor_if bus2 ();
    output_signature_monitor_if bus8 ();

    output_signature_monitor #(.WIN(1), .SEED(20'h00000), .EVT_MASK(20'h00008), .ALARM_TH(5))
        dut_w1 (.clk(clk), .rst(rst), .bus(bus1));
    output_signature_monitor #(.WIN(2), .SEED(20'h00000), .EVT_MASK(20'h00008), .ALARM_TH(5))
        dut_w2 (.clk(clk), .rst(rst), .bus(bus2));
    output_signature_monitor #(.WIN(8), .SEED(20'h00000), .EVT_MASK(20'h00008), .ALARM_TH(5))
        dut_w8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fails = 0;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q8[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic s8(input logic v, input logic [19:0] y);
        bus8.sample_valid = v;
        bus8.y_in         = y;
        tick();
        bus8.sample_valid = 1'b0;
        bus8.y_in         = 20'h00000;
    endtask

    function automatic exp_t mk(input logic [19:0] s, input logic [7:0] ec, input logic al);
        exp_t e;
        e.sig   = s;
        e.ec    = ec;
        e.alarm = al;
        return e;
    endfunction

    // ------------------------------------------------------------ monitors
    logic seen1 = 1'b0;
    logic seen2 = 1'b0;
    logic seen8 = 1'b0;
    exp_t e1, e2, e8;

    always @(negedge clk) begin
        if (bus1.sig_valid && !seen1) begin
            if (q1.size() == 0) check("w1_unexpected_done", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("w1_sig", bus1.sig, e1.sig);
                check("w1_event_count", bus1.event_count, e1.ec);
                check("w1_alarm", bus1.alarm, e1.alarm);
            end
        end
        seen1 = bus1.sig_valid;
    end

    always @(negedge clk) begin
        if (bus2.sig_valid && !seen2) begin
            if (q2.size() == 0) check("w2_unexpected_done", 32'd1, 32'd0);
            else begin
                e2 = q2.pop_front();
                check("w2_sig", bus2.sig, e2.sig);
                check("w2_event_count", bus2.event_count, e2.ec);
                check("w2_alarm", bus2.alarm, e2.alarm);
            end
        end
        seen2 = bus2.sig_valid;
    end

    always @(negedge clk) begin
        if (bus8.sig_valid && !seen8) begin
            if (q8.size() == 0) check("w8_unexpected_done", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                check("w8_sig", bus8.sig, e8.sig);
                check("w8_event_count", bus8.event_count, e8.ec);
                check("w8_alarm", bus8.alarm, e8.alarm);
            end
        end
        seen8 = bus8.sig_valid;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        n_fails++;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    // MISR after each of the five bit3 samples in the WIN=8 event window.
    logic [19:0] evt_sig [5];
    logic [7:0]  ec5;

    // ------------------------------------------------------------ stimulus
    initial begin
        evt_sig[0] = 20'h00008;
        evt_sig[1] = 20'h00018;
        evt_sig[2] = 20'h00038;
        evt_sig[3] = 20'h00078;
        evt_sig[4] = 20'h000F8;
        ec5 = ALARM_EN ? 8'd5 : 8'd0;

        rst = 1'b1;
        {bus1.start, bus1.clear, bus1.sample_valid, bus1.ack} = 4'b0;
        {bus2.start, bus2.clear, bus2.sample_valid, bus2.ack} = 4'b0;
        {bus8.start, bus8.clear, bus8.sample_valid, bus8.ack} = 4'b0;
        bus1.y_in = 20'h0;
        bus2.y_in = 20'h0;
        bus8.y_in = 20'h0;

        #12;
        check("rst_busy", bus8.busy, 32'd0);
        check("rst_sig_valid", bus8.sig_valid, 32'd0);
        check("rst_sig", bus8.sig, 32'h0);
        check("rst_event_count", bus8.event_count, 32'd0);
        check("rst_alarm", bus8.alarm, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---- WIN=1: single sample 0x00001 -> sig 0x00001 next cycle
        q1.push_back(mk(20'h00001, 8'd0, 1'b0));
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("w1_busy", bus1.busy, 32'd1);
        bus1.sample_valid = 1'b1;
        bus1.y_in         = 20'h00001;
        tick();
        bus1.sample_valid = 1'b0;
        bus1.y_in         = 20'h00000;
        check("w1_latency_sig_valid", bus1.sig_valid, 32'd1);
        check("w1_done_busy", bus1.busy, 32'd0);
        tick();
        bus1.ack = 1'b1;
        tick();
        bus1.ack = 1'b0;
        check("w1_ack_idle", bus1.sig_valid, 32'd0);

        // ---- WIN=2: 0x00001, 0x00000 -> 0x00002; start+ack in DONE
        q2.push_back(mk(20'h00002, 8'd0, 1'b0));
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.sample_valid = 1'b1;
        bus2.y_in         = 20'h00001;
        tick();
        check("w2_not_done_early", bus2.sig_valid, 32'd0);
        bus2.y_in = 20'h00000;
        tick();
        bus2.sample_valid = 1'b0;
        check("w2_latency_sig_valid", bus2.sig_valid, 32'd1);
        tick();
        check("w2_done_hold", bus2.sig_valid, 32'd1);
        bus2.start = 1'b1;
        bus2.ack   = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.ack   = 1'b0;
        check("w2_start_ack_busy", bus2.busy, 32'd0);
        check("w2_start_ack_sig_valid", bus2.sig_valid, 32'd0);
        tick();
        check("w2_start_dropped", bus2.busy, 32'd0);

        // ---- WIN=8: five bit3 events with invalid gaps, then three zeros
        q8.push_back(mk(20'h007C0, ec5, ALARM_EN));
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s8(1'b1, 20'h00008);
            if (i == 3) begin
                check("w8_ec_before_th", bus8.event_count, ALARM_EN ? 32'd4 : 32'd0);
                check("w8_alarm_before_th", bus8.alarm, 32'd0);
            end
            if (i == 4) begin
                check("w8_ec_at_th", bus8.event_count, ec5);
                check("w8_alarm_at_th", bus8.alarm, ALARM_EN);
            end
            s8(1'b0, 20'hFFFFF);
            check("w8_gap_sig", bus8.sig, evt_sig[i]);
        end
        s8(1'b1, 20'h00000);
        s8(1'b1, 20'h00000);
        check("w8_busy_before_last", bus8.busy, 32'd1);
        check("w8_not_done_early", bus8.sig_valid, 32'd0);
        s8(1'b1, 20'h00000);
        check("w8_latency_sig_valid", bus8.sig_valid, 32'd1);
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        check("w8_done_ignores_start", bus8.sig_valid, 32'd1);
        check("w8_done_hold_alarm", bus8.alarm, ALARM_EN);
        check("w8_done_hold_ec", bus8.event_count, ec5);
        bus8.ack = 1'b1;
        tick();
        bus8.ack = 1'b0;

        // ---- WIN=8: exercise feedback taps 16 and 19
        q8.push_back(mk(20'h00048, 8'd0, 1'b0));
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        check("w8_start_clears_alarm", bus8.alarm, 32'd0);
        check("w8_start_clears_ec", bus8.event_count, 32'd0);
        s8(1'b1, 20'h10000);
        for (int i = 0; i < 7; i++) s8(1'b1, 20'h00000);
        check("w8_fb_sig_valid", bus8.sig_valid, 32'd1);
        bus8.ack = 1'b1;
        tick();
        bus8.ack = 1'b0;

        // ---- reset mid-window after 3 samples
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 3; i++) s8(1'b1, 20'h00008);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", bus8.busy, 32'd0);
        check("midrst_sig", bus8.sig, 32'h0);
        check("midrst_event_count", bus8.event_count, 32'd0);
        check("midrst_sig_valid", bus8.sig_valid, 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) s8(1'b1, 20'h00008);
        check("midrst_waits_busy", bus8.busy, 32'd0);
        check("midrst_waits_sig_valid", bus8.sig_valid, 32'd0);
        check("midrst_waits_sig", bus8.sig, 32'h0);

        // ---- clear during COLLECT, simultaneous with a valid sample
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        s8(1'b1, 20'h00008);
        s8(1'b1, 20'h00008);
        check("clr_pre_ec", bus8.event_count, ALARM_EN ? 32'd2 : 32'd0);
        bus8.clear        = 1'b1;
        bus8.sample_valid = 1'b1;
        bus8.y_in         = 20'h00008;
        tick();
        bus8.clear        = 1'b0;
        bus8.sample_valid = 1'b0;
        bus8.y_in         = 20'h00000;
        check("clr_busy", bus8.busy, 32'd0);
        check("clr_event_count", bus8.event_count, 32'd0);
        check("clr_sig_hold", bus8.sig, 32'h00018);
        tick();
        check("clr_stays_idle", bus8.busy, 32'd0);

        tick();
        check("q1_drained", q1.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        check("q8_drained", q8.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
